// File: rtl/vga_scanout.sv
// Parametrised VGA scan-out: sync timing, windowed VRAM fetch (RGB222 or Hack-layout mono), 2-tick output pipeline.
// Define VGA_BORDER_EN to add border_color for active pixels outside the framebuffer window.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_POL    = 0,
  parameter int WIN_X       = 64,
  parameter int WIN_Y       = 112,
  parameter int SCALE_SHIFT = 0,
  parameter int FB_W        = 512,
  parameter int FB_H        = 256,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clken,
  input  logic              mode,
  input  logic [5:0]        fg_color,
  input  logic [5:0]        bg_color,
  output logic [ADDR_W-1:0] vram_raddr,
  input  logic [15:0]       vram_rdata,
  output logic              h_sync,
  output logic              v_sync,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              frame_start
`ifdef VGA_BORDER_EN
  ,
  input  logic [5:0]        border_color
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int S  = SCALE_SHIFT;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG      = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END      = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_BEG      = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END      = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [HW-1:0] WX_BEG      = HW'(WIN_X);
  localparam logic [HW-1:0] WX_END      = HW'(WIN_X + (FB_W << S));
  localparam logic [VW-1:0] WY_BEG      = VW'(WIN_Y);
  localparam logic [VW-1:0] WY_END      = VW'(WIN_Y + (FB_H << S));
  localparam logic [HW-1:0] H_WORD_MONO = HW'((16 << S) - 1);
  localparam logic [HW-1:0] H_WORD_RGB  = HW'((2 << S) - 1);
  localparam logic [HW-1:0] H_REP       = HW'((1 << S) - 1);
  localparam logic [VW-1:0] V_REP       = VW'((1 << S) - 1);
  localparam logic [ADDR_W-1:0] WPL_MONO = ADDR_W'(FB_W / 16);
  localparam logic [ADDR_W-1:0] WPL_RGB  = ADDR_W'(FB_W / 2);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [HW-1:0]     h_cnt_q, h_cnt_d, h_rel, word_mask;
  logic [VW-1:0]     v_cnt_q, v_cnt_d, v_rel;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d, word_off_q, word_off_d, wpl, raddr_q;
  logic [15:0]       shreg_q, shreg_d;
  logic              s1_act_q, s1_act_d, s1_win_q, s1_win_d;
  logic              s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_fs_q, s1_fs_d;
  logic              hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [5:0]        rgb_q, rgb_d, pix_color, off_win_color;
  logic              h_last, v_last, win_h, win_v, in_win, active;
  logic              word_start, px_step, row_end;

  always_comb begin
    h_last     = (h_cnt_q == H_LAST);
    v_last     = (v_cnt_q == V_LAST);
    h_rel      = h_cnt_q - WX_BEG;
    v_rel      = v_cnt_q - WY_BEG;
    win_h      = (h_cnt_q >= WX_BEG) && (h_cnt_q < WX_END);
    win_v      = (v_cnt_q >= WY_BEG) && (v_cnt_q < WY_END);
    in_win     = win_h && win_v;
    active     = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    word_mask  = mode_q ? H_WORD_MONO : H_WORD_RGB;
    wpl        = mode_q ? WPL_MONO : WPL_RGB;
    word_start = in_win && ((h_rel & word_mask) == '0);
    px_step    = in_win && ((h_rel & H_REP) == '0);
    // line_base advances after the last replicated copy of each source line
    row_end    = win_v && ((v_rel & V_REP) == V_REP);
    pix_color  = mode_q ? (shreg_q[0] ? fg_color : bg_color) : shreg_q[13:8];
`ifdef VGA_BORDER_EN
    off_win_color = border_color;
`else
    off_win_color = '0;
`endif
  end

  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    mode_d      = mode_q;
    line_base_d = line_base_q;
    word_off_d  = word_off_q;
    shreg_d     = shreg_q;
    s1_act_d    = s1_act_q;
    s1_win_d    = s1_win_q;
    s1_hs_d     = s1_hs_q;
    s1_vs_d     = s1_vs_q;
    s1_fs_d     = s1_fs_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    rgb_d       = rgb_q;
    fs_d        = clken && s1_fs_q;
    if (clken) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
      if (h_last) begin
        v_cnt_d    = v_last ? '0 : v_cnt_q + 1'b1;
        word_off_d = '0;
        if (v_last) begin
          line_base_d = '0;
          mode_d      = mode;
        end else if (row_end) begin
          line_base_d = line_base_q + wpl;
        end
      end
      // word_off saturates so the address never runs into the next source line
      if (word_start) begin
        shreg_d = vram_rdata;
        if (word_off_q != wpl - 1'b1) word_off_d = word_off_q + 1'b1;
      end else if (px_step) begin
        shreg_d = mode_q ? {1'b0, shreg_q[15:1]} : {shreg_q[7:0], 8'h00};
      end
      s1_act_d = active;
      s1_win_d = in_win;
      s1_hs_d  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      s1_vs_d  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      s1_fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
      hs_d     = s1_hs_q ? SYNC_ON : ~SYNC_ON;
      vs_d     = s1_vs_q ? SYNC_ON : ~SYNC_ON;
      rgb_d    = !s1_act_q ? '0 : (s1_win_q ? pix_color : off_win_color);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      mode_q      <= mode;
      line_base_q <= '0;
      word_off_q  <= '0;
      shreg_q     <= '0;
      raddr_q     <= '0;
      s1_act_q    <= 1'b0;
      s1_win_q    <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_fs_q     <= 1'b0;
      hs_q        <= ~SYNC_ON;
      vs_q        <= ~SYNC_ON;
      rgb_q       <= '0;
      fs_q        <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      mode_q      <= mode_d;
      line_base_q <= line_base_d;
      word_off_q  <= word_off_d;
      shreg_q     <= shreg_d;
      raddr_q     <= line_base_d + word_off_d;
      s1_act_q    <= s1_act_d;
      s1_win_q    <= s1_win_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_fs_q     <= s1_fs_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rgb_q       <= rgb_d;
      fs_q        <= fs_d;
    end
  end

  assign vram_raddr  = raddr_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign red         = {rgb_q[5:4], rgb_q[5:4]};
  assign green       = {rgb_q[3:2], rgb_q[3:2]};
  assign blue        = {rgb_q[1:0], rgb_q[1:0]};
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two instances (1x active-low sync, 2x active-high sync) on a reduced raster,
// checked every clk against a pixel-level model plus hand-computed pixel/sync/address points.
module tb_vga_scanout;
  localparam int HA = 96, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int WX = 16, WY = 4, FBH = 8, AW = 10;

  logic clk, resetn, clken, mode;
  logic [5:0] fg, bg, border;
  logic [AW-1:0] raddr0, raddr1;
  logic [15:0] rdata0, rdata1;
  logic hs0, vs0, fs0, hs1, vs1, fs1;
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic [15:0] vram0 [0:1023];
  logic [15:0] vram1 [0:1023];

  int n_pass = 0, n_total = 0;
  int n_ticks = 0;
  bit rst_seen = 0;
  bit fmode [8];

  vga_scanout #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0),
    .WIN_X(WX), .WIN_Y(WY), .SCALE_SHIFT(0), .FB_W(64), .FB_H(FBH), .ADDR_W(AW)) dut0 (
    .clk(clk), .resetn(resetn), .clken(clken), .mode(mode), .fg_color(fg), .bg_color(bg),
    .vram_raddr(raddr0), .vram_rdata(rdata0), .h_sync(hs0), .v_sync(vs0),
    .red(r0), .green(g0), .blue(b0), .frame_start(fs0)
`ifdef VGA_BORDER_EN
    , .border_color(border)
`endif
  );

  vga_scanout #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1),
    .WIN_X(WX), .WIN_Y(WY), .SCALE_SHIFT(1), .FB_W(16), .FB_H(FBH), .ADDR_W(AW)) dut1 (
    .clk(clk), .resetn(resetn), .clken(clken), .mode(mode), .fg_color(fg), .bg_color(bg),
    .vram_raddr(raddr1), .vram_rdata(rdata1), .h_sync(hs1), .v_sync(vs1),
    .red(r1), .green(g1), .blue(b1), .frame_start(fs1)
`ifdef VGA_BORDER_EN
    , .border_color(border)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata0 <= vram0[raddr0];
    rdata1 <= vram1[raddr1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [11:0] rep(input logic [5:0] c);
    return {c[5:4], c[5:4], c[3:2], c[3:2], c[1:0], c[1:0]};
  endfunction

  function automatic logic [15:0] mem(input int d, input int a);
    return (d == 0) ? vram0[a] : vram1[a];
  endfunction

  // Colour a pixel must show, straight from screen coordinates and framebuffer contents
  function automatic logic [5:0] exp_color(input int d, input int x, input int y, input bit m);
    int s, fbw, sx, sy, wpl;
    logic [15:0] w;
    s = (d == 0) ? 0 : 1;
    fbw = (d == 0) ? 64 : 16;
    if (x >= HA || y >= VA) return 6'd0;
    if (x < WX || x >= WX + (fbw << s) || y < WY || y >= WY + (FBH << s)) begin
`ifdef VGA_BORDER_EN
      return border;
`else
      return 6'd0;
`endif
    end
    sx = (x - WX) >> s;
    sy = (y - WY) >> s;
    wpl = m ? fbw / 16 : fbw / 2;
    if (m) begin
      w = mem(d, sy * wpl + sx / 16);
      return w[sx % 16] ? fg : bg;
    end
    w = mem(d, sy * wpl + sx / 2);
    return (sx % 2 == 0) ? w[13:8] : w[5:0];
  endfunction

  function automatic logic exp_sync(input int c, input int beg, input int len, input int pol);
    logic act;
    act = (c >= beg) && (c < beg + len);
    return (pol != 0) ? act : !act;
  endfunction

  // Address after the counter has reached (cx,cy): row base plus words already fetched on this line
  function automatic int exp_raddr(input int d, input int cx, input int cy, input bit m);
    int s, fbw, wpl, ppw, base, loads, row;
    s = (d == 0) ? 0 : 1;
    fbw = (d == 0) ? 64 : 16;
    wpl = m ? fbw / 16 : fbw / 2;
    ppw = (m ? 16 : 2) << s;
    row = (cy < WY) ? 0 : (cy - WY) >> s;
    if (row > FBH) row = FBH;
    base = row * wpl;
    loads = 0;
    if (cy >= WY && cy < WY + (FBH << s) && cx - 1 >= WX) begin
      loads = (cx - 1 - WX) / ppw + 1;
      if (loads > wpl) loads = wpl;
    end
    if (loads > wpl - 1) loads = wpl - 1;
    return base + loads;
  endfunction

  initial begin : compare
    logic tk, rs, md;
    int p, px, py, cx, cy;
    bit pm, cm;
    forever begin
      @(posedge clk);
      tk = clken; rs = resetn; md = mode;
      @(negedge clk);
      if (!rs) begin
        n_ticks = 0; fmode[0] = md; rst_seen = 1;
      end else if (rst_seen && tk) begin
        n_ticks++;
        if (n_ticks % FT == 0) fmode[(n_ticks / FT) % 8] = md;
      end
      if (rst_seen) begin
        cx = n_ticks % HT; cy = (n_ticks / HT) % VT; cm = fmode[(n_ticks / FT) % 8];
        chk("raddr0", 32'(raddr0), exp_raddr(0, cx, cy, cm));
        chk("raddr1", 32'(raddr1), exp_raddr(1, cx, cy, cm));
        if (cm && cy == 4 && cx == 17) chk("lit_raddr0_w1", 32'(raddr0), 1);
        if (cm && cy == 4 && cx == 33) chk("lit_raddr0_w2", 32'(raddr0), 2);
        if (cm && cy == 4 && cx == 49) chk("lit_raddr0_w3", 32'(raddr0), 3);
        if (cm && cy == 4 && cx == 65) chk("lit_raddr0_sat", 32'(raddr0), 3);
        if (cm && cy == 5 && cx == 0) chk("lit_raddr0_line5", 32'(raddr0), 4);
        if (!cm && cy == 5 && cx == 0) chk("lit_raddr1_rep", 32'(raddr1), 0);
        if (!cm && cy == 5 && cx == 17) chk("lit_raddr1_rep_w1", 32'(raddr1), 1);
        if (!cm && cy == 6 && cx == 0) chk("lit_raddr1_next", 32'(raddr1), 8);
        if (n_ticks < 2) begin
          chk("hs0_idle", hs0, 1); chk("vs0_idle", vs0, 1);
          chk("hs1_idle", hs1, 0); chk("vs1_idle", vs1, 0);
          chk("rgb0_idle", {r0, g0, b0}, 0); chk("rgb1_idle", {r1, g1, b1}, 0);
          chk("fs0_idle", fs0, 0); chk("fs1_idle", fs1, 0);
        end else begin
          p = n_ticks - 2;
          px = p % HT; py = (p / HT) % VT; pm = fmode[(p / FT) % 8];
          chk("hs0", hs0, exp_sync(px, HA + HF, HS, 0));
          chk("vs0", vs0, exp_sync(py, VA + VF, VS, 0));
          chk("hs1", hs1, exp_sync(px, HA + HF, HS, 1));
          chk("vs1", vs1, exp_sync(py, VA + VF, VS, 1));
          chk("rgb0", {r0, g0, b0}, rep(exp_color(0, px, py, pm)));
          chk("rgb1", {r1, g1, b1}, rep(exp_color(1, px, py, pm)));
          chk("fs0", fs0, tk && (p % FT == 0));
          chk("fs1", fs1, tk && (p % FT == 0));
          if (pm && py == 4 && px == 16) begin
            chk("lit_mono_on", {r0, g0, b0}, 12'hF00);
            chk("pin_model_mono", rep(exp_color(0, 16, 4, 1'b1)), 12'hF00);
          end
          if (pm && py == 4 && px == 17) chk("lit_mono_off", {r0, g0, b0}, 12'h000);
          if (!pm && py == 4 && px == 16) chk("lit_rgb_px0", {r0, g0, b0}, 12'h000);
          if (!pm && py == 4 && px == 17) chk("lit_rgb_px1", {r0, g0, b0}, 12'h005);
          if (!pm && (py == 4 || py == 5) && (px == 16 || px == 17)) begin
            chk("lit_x2_green", {r1, g1, b1}, 12'h0F0);
            chk("pin_model_x2", rep(exp_color(1, px, py, 1'b0)), 12'h0F0);
          end
          if (!pm && py == 4 && (px == 18 || px == 19)) chk("lit_x2_blue", {r1, g1, b1}, 12'h00F);
          if (py == 5 && px == 99) chk("lit_hs0_pre", hs0, 1);
          if (py == 5 && px == 100) begin chk("lit_hs0_on", hs0, 0); chk("lit_hs1_on", hs1, 1); end
          if (py == 5 && px == 107) chk("lit_hs0_last", hs0, 0);
          if (py == 5 && px == 108) chk("lit_hs0_post", hs0, 1);
          if (px == 0 && py == 25) chk("lit_vs0_pre", vs0, 1);
          if (px == 0 && py == 26) begin chk("lit_vs0_on", vs0, 0); chk("lit_vs1_on", vs1, 1); end
          if (px == 0 && py == 27) chk("lit_vs0_last", vs0, 0);
          if (px == 0 && py == 28) chk("lit_vs0_post", vs0, 1);
`ifdef VGA_BORDER_EN
          if (px == 10 && py == 10) chk("lit_border", {r0, g0, b0}, 12'h00F);
`else
          if (px == 10 && py == 10) chk("lit_border", {r0, g0, b0}, 12'h000);
`endif
        end
      end
    end
  end

  task automatic wait_n(input int target);
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk);
      if (n_ticks >= target) begin
        #1;
        return;
      end
    end
    n_total++;
    $display("FAIL wait_n: n_ticks=%0d, required %0d", n_ticks, target);
    #1;
  endtask

  initial begin : clken_gen
    clken = 1'b0;
    forever begin
      @(posedge clk);
      #1 clken = ~clken;
    end
  end

  initial begin : main
    clk = 1'b0;
    resetn = 1'b0;
    mode = 1'b0;
    fg = 6'b110000;
    bg = 6'b000000;
    border = 6'b000011;
    for (int i = 0; i < 1024; i++) begin
      vram0[i] = 16'(i * 40503 + 7);
      vram1[i] = 16'(i * 12345 + 3);
    end
    vram0[0] = 16'h0001;
    vram1[0] = 16'h0C03;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    // switch to mono inside frame 0; frame 0 must stay RGB222
    wait_n(2 * HT + 50);
    mode = 1'b1;
    wait_n(2 * FT + 10 * HT + 50);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    chk("rst_hs0", hs0, 1); chk("rst_vs0", vs0, 1);
    chk("rst_hs1", hs1, 0); chk("rst_vs1", vs1, 0);
    chk("rst_rgb0", {r0, g0, b0}, 0); chk("rst_fs0", fs0, 0);
    chk("rst_raddr0", 32'(raddr0), 0);
    wait_n(FT + 2 * HT);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
